load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clock and reset.
REQ-002 Parameters SHALL be: none; all widths fixed at 32-bit data and 32-bit byte address.
REQ-003 Port list, one per line, SHALL be as follows.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req  in  1  start access; sampled only when busy=0
- op  in  4  MIPS opcode[3:0]: bit3 store, bit2 unsigned, bits1:0 size (00 byte, 01 half, 11 word, 10 treated as word)
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rt)
- busy  out  1  access in progress; CPU stalls
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, extended
- misalign  out  1  misaligned flag, valid with done
- mem_address  out  32  word index to data memory = {2'b00, addr[31:2]}
- mem_writeData  out  32  merged write word
- mem_memWrite  out  1  write strobe
- mem_memRead  out  1  read strobe
- mem_readData  in  32  data memory read word

Function
REQ-004 FSM states SHALL be IDLE, READ, CAPT, WRITE, HOLD, DONE; busy = (state != IDLE).
REQ-005 IDLE with req=1 at an edge SHALL latch op, addr, wdata; next state READ for loads and sub-word stores, WRITE for word stores.
REQ-006 mem_memRead SHALL be 1 only in READ; mem_memWrite SHALL be 1 only in WRITE; both single-cycle pulses.
REQ-007 mem_address SHALL be driven from the latched address in every non-IDLE state and held stable through HOLD.
REQ-008 READ SHALL go to CAPT; on the edge leaving CAPT, mem_readData SHALL be registered internally.
REQ-009 CAPT SHALL go to DONE for loads and to WRITE for byte/half stores.
REQ-010 WRITE SHALL go to HOLD; HOLD SHALL go to DONE; DONE SHALL go to IDLE.
REQ-011 done SHALL be 1 only in DONE; latency from accepting edge to done: loads 3 cycles, sw 3 cycles, sb/sh 5 cycles.
REQ-012 Byte order SHALL be little-endian: byte lane k = bits [8k+7:8k], k = addr[1:0]; half lane = addr[1].
REQ-013 Loads: rdata SHALL be updated on the edge entering DONE with the selected lane, sign-extended when op[2]=0, zero-extended when op[2]=1; rdata holds until next load completes.
REQ-014 Sub-word stores: mem_writeData SHALL be the captured word with only the selected lane replaced by wdata[7:0] or wdata[15:0]; sw SHALL write wdata unmodified.
REQ-015 req while busy=1 SHALL be ignored, not queued; req in DONE SHALL also be ignored.
REQ-016 Input changes on addr/op/wdata after acceptance SHALL NOT affect the access in flight.

Reset
REQ-017 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, misalign=0, rdata=0, mem_memRead=0, mem_memWrite=0, mem_address=0, mem_writeData=0.
REQ-018 Reset mid-access SHALL abort it: no strobe asserted in the cycle after the reset edge, no done pulse; a sub-word store aborted before WRITE SHALL leave memory unchanged.
REQ-019 reset SHALL take priority over req at the same edge.

Configuration
REQ-020 Macro LSU_ALIGN_CHECK_EN, when defined, SHALL detect misalignment (half with addr[0]=1, word with addr[1:0]!=0): IDLE goes directly to DONE, no memory strobes, misalign=1 with done, rdata unchanged.
REQ-021 Without LSU_ALIGN_CHECK_EN, misalign SHALL be tied 0 and address bits below the access size SHALL be treated as zero.

Verification
REQ-022 mem[5]=0x80FF7F01; lb addr=0x16 -> done 3 cycles after accept, rdata=0xFFFFFFFF; lbu addr=0x17 -> rdata=0x00000080.
REQ-023 mem[5]=0x80FF7F01; lh addr=0x16 -> rdata=0xFFFF80FF; lhu addr=0x14 -> rdata=0x00007F01.
REQ-024 mem[2]=0x11223344; sb addr=0x09 wdata=0xAB -> one memRead, one memWrite, done after 5 cycles, mem[2]=0x1122AB44.
REQ-025 sw addr=0x0C wdata=0xDEADBEEF -> no memRead pulse, mem[3]=0xDEADBEEF, done after 3 cycles; second req during busy ignored.
REQ-026 sh addr=0x0A, reset asserted in CAPT -> no memWrite pulse, no done, mem[2] unchanged, all outputs 0.
REQ-027 With LSU_ALIGN_CHECK_EN: lw addr=0x0E -> done and misalign=1 one cycle after accept, no strobes; without the macro -> reads mem[3].

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Multi-cycle load/store unit sitting between a MIPS-style CPU and a
//   word-addressed data memory. The CPU issues one access at a time with
//   req, then stalls on busy. The unit handles byte/half/word loads with
//   sign or zero extension. Sub-word stores are done as read-modify-write
//   so that only the selected lane of the memory word changes. Byte order
//   is little-endian.
//
//   Access sequences (state after each clock edge):
//     load            : READ -> CAPT -> DONE -> IDLE
//     sw              : WRITE -> HOLD -> DONE -> IDLE
//     sb / sh         : READ -> CAPT -> WRITE -> HOLD -> DONE -> IDLE
//     misaligned (*)  : DONE -> IDLE
//
// Optional feature:
//   LSU_ALIGN_CHECK_EN -- when defined, a half access with addr[0]=1 or a
//   word access with addr[1:0]!=0 is flagged on misalign together with done.
//   No memory strobe is issued and rdata is left unchanged. When the macro
//   is not defined, misalign is tied low and the address bits below the
//   access size are ignored.
//
// Ports:
//   clock          in   1  rising-edge clock
//   reset          in   1  synchronous, active-high
//   req            in   1  start access, sampled only while busy=0
//   op             in   4  bit3 store, bit2 unsigned, bits1:0 size
//                          (00 byte, 01 half, 1x word)
//   addr           in  32  byte address
//   wdata          in  32  store data
//   busy           out  1  access in progress
//   done           out  1  one-cycle completion pulse
//   rdata          out 32  extended load result
//   misalign       out  1  misaligned flag, valid with done
//   mem_address    out 32  word index {2'b00, addr[31:2]}
//   mem_writeData  out 32  merged write word
//   mem_memWrite   out  1  write strobe
//   mem_memRead    out  1  read strobe
//   mem_readData   in  32  read word from data memory
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } lsuState_t;

  lsuState_t   r_state;

  // Access parameters captured on the accepting edge, so that later changes
  // on op/addr/wdata cannot disturb the access in flight.
  logic        r_isStore;
  logic        r_isUnsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  // Registered outputs
  logic [31:0] r_memAddress;
  logic [31:0] r_writeData;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_memRead;
  logic        r_memWrite;

  logic        w_misaligned;
  logic        w_wordStore;

  // Selects the addressed lane of a memory word and extends it to 32 bits.
  // Word accesses ignore the lane bits entirely, so an unaligned word load
  // simply returns the containing word.
  function automatic logic [31:0] extractLoad(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        isUnsigned
  );
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    byteVal = word[{lane, 3'b000} +: 8];
    halfVal = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   result = isUnsigned ? {24'h000000, byteVal}
                                   : {{24{byteVal[7]}}, byteVal};
      2'b01:   result = isUnsigned ? {16'h0000, halfVal}
                                   : {{16{halfVal[15]}}, halfVal};
      default: result = word;
    endcase
    return result;
  endfunction

  // Replaces only the addressed lane of the captured word with store data.
  function automatic logic [31:0] mergeStore(
    input logic [31:0] word,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] result;
    result = word;
    case (size)
      2'b00:   result[{lane, 3'b000} +: 8]     = data[7:0];
      2'b01:   result[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: result = data;
    endcase
    return result;
  endfunction

  // Word stores skip the read phase because nothing has to be preserved.
  assign w_wordStore = op[3] & op[1];

`ifdef LSU_ALIGN_CHECK_EN
  logic r_misalign;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are never misaligned.
  assign w_misaligned = (op[1:0] == 2'b01) ? addr[0]
                      : (op[1] ? (addr[1:0] != 2'b00) : 1'b0);
  assign misalign     = r_misalign;
`else
  assign w_misaligned = 1'b0;
  assign misalign     = 1'b0;
`endif

  // Main sequencer. Strobes and done are defaulted low every cycle and only
  // raised on the edge entering the state that owns them, which makes each
  // of them a single-cycle registered pulse. Reset wins over req and clears
  // every output register, aborting any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_isStore    <= 1'b0;
      r_isUnsigned <= 1'b0;
      r_size       <= 2'b00;
      r_lane       <= 2'b00;
      r_wdata      <= 32'h0;
      r_memAddress <= 32'h0;
      r_writeData  <= 32'h0;
      r_rdata      <= 32'h0;
      r_done       <= 1'b0;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      r_misalign   <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (req) begin
            r_isStore    <= op[3];
            r_isUnsigned <= op[2];
            r_size       <= op[1:0];
            r_lane       <= addr[1:0];
            r_wdata      <= wdata;
            r_memAddress <= {2'b00, addr[31:2]};
            if (w_misaligned) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
              r_misalign <= 1'b1;
`endif
            end else if (w_wordStore) begin
              r_state     <= WRITE;
              r_memWrite  <= 1'b1;
              r_writeData <= wdata;
            end else begin
              r_state   <= READ;
              r_memRead <= 1'b1;
            end
          end
        end

        READ: begin
          r_state <= CAPT;
        end

        // Memory returns the word during CAPT; it is consumed on the edge
        // leaving CAPT, either as a load result or as the base for a merge.
        CAPT: begin
          if (r_isStore) begin
            r_writeData <= mergeStore(mem_readData, r_wdata, r_size, r_lane);
            r_memWrite  <= 1'b1;
            r_state     <= WRITE;
          end else begin
            r_rdata <= extractLoad(mem_readData, r_size, r_lane, r_isUnsigned);
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        WRITE: begin
          r_state <= HOLD;
        end

        HOLD: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end

        // req is deliberately not looked at here; the CPU must see busy low
        // before a new access can be accepted.
        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign mem_address   = r_memAddress;
  assign mem_writeData = r_writeData;
  assign mem_memWrite  = r_memWrite;
  assign mem_memRead   = r_memRead;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A 64-word data memory is served
// by the bench itself. A separate reference memory plus arithmetic
// load/store rules give the expected results. Directed scenarios come
// first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  logic [31:0] mem    [64];
  logic [31:0] refMem [64];
  logic [31:0] expRdata;
  int          nVectors;
  int          nMiscompares;

  load_store_unit dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .op            (op),
    .addr          (addr),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .rdata         (rdata),
    .misalign      (misalign),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .mem_readData  (mem_readData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic int accessBytes(input logic [3:0] o);
    int nb;
    case (o[1:0])
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      default: nb = 4;
    endcase
    return nb;
  endfunction

  function automatic bit modelMisaligned(input logic [3:0] o, input logic [31:0] a);
    int lowBits;
    lowBits = int'(a[1:0]);
    return ALIGN_EN && ((lowBits % accessBytes(o)) != 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [3:0] o,
                                            input logic [31:0] a);
    longint unsigned span, value;
    int nb, offset;
    nb     = accessBytes(o);
    offset = (int'(a[1:0]) / nb) * nb;
    span   = 64'd1 << (8 * nb);
    value  = (64'(word) >> (8 * offset)) % span;
    if (!o[2] && (value >= span / 2))
      value = value + 64'h1_0000_0000 - span;
    return value[31:0];
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [3:0] o,
                                             input logic [31:0] a, input logic [31:0] d);
    longint unsigned span, mask, result;
    int nb, offset;
    nb     = accessBytes(o);
    offset = (int'(a[1:0]) / nb) * nb;
    span   = 64'd1 << (8 * nb);
    mask   = (span - 1) << (8 * offset);
    result = (64'(word) & ~mask) | ((64'(d) % span) << (8 * offset));
    return result[31:0];
  endfunction

  // ---------------- clocking and memory service ----------------
  // Advances one clock. Strobes are sampled mid-cycle and the memory acts
  // on them just after the edge, so read data is available in the
  // following cycle.
  task automatic step();
    logic        rd, wr;
    logic [5:0]  wa;
    logic [31:0] wd;
    @(negedge clock);
    rd = mem_memRead;
    wr = mem_memWrite;
    wa = mem_address[5:0];
    wd = mem_writeData;
    @(posedge clock);
    #1;
    if (rd === 1'b1) mem_readData = mem[wa];
    if (wr === 1'b1) mem[wa] = wd;
  endtask

  // Issues one access and records what the DUT did until done (bounded).
  // With scramble set, req stays high and op/addr/wdata are randomized while
  // busy, including in the DONE cycle.
  task automatic runAccess(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                           input bit scramble, output int latency, output int nRead,
                           output int nWrite, output bit addrStable,
                           output logic [31:0] doneRdata, output logic doneMisalign,
                           output logic postBusy, output logic postDone);
    latency      = 0;
    nRead        = 0;
    nWrite       = 0;
    addrStable   = 1'b1;
    doneRdata    = 32'h0;
    doneMisalign = 1'b0;
    req   = 1'b1;
    op    = o;
    addr  = a;
    wdata = d;
    step();
    for (int k = 1; k <= 12; k++) begin
      if (mem_memRead === 1'b1) nRead++;
      if (mem_memWrite === 1'b1) nWrite++;
      if (busy === 1'b1 && mem_address !== (a >> 2)) addrStable = 1'b0;
      if (done === 1'b1) begin
        latency      = k;
        doneRdata    = rdata;
        doneMisalign = misalign;
        break;
      end
      if (scramble) begin
        req   = 1'b1;
        op    = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      step();
    end
    step();
    req      = 1'b0;
    postBusy = busy;
    postDone = done;
  endtask

  // ---------------- scenarios ----------------
  // Reset held with req high: every output must be zero and nothing starts.
  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b1;
    op    = OP_LW;
    addr  = 32'h14;
    wdata = 32'h0;
    step();
    step();
    nVectors += 8;
    if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (misalign !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
    if (rdata !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    if (mem_memRead !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_memRead: got %b expected 0", mem_memRead); end
    if (mem_memWrite !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_memWrite: got %b expected 0", mem_memWrite); end
    if (mem_address !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_address: got %h expected 0", mem_address); end
    if (mem_writeData !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_writeData: got %h expected 0", mem_writeData); end
    reset = 1'b0;
    req   = 1'b0;
    step();
    nVectors++;
    if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
    expRdata = 32'h0;
  endtask

  // Directed sub-word loads from a known word with both extension kinds.
  task automatic test_loads();
    logic [3:0]  ops  [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    int lat, nr, nw;
    bit stable;
    logic [31:0] gotRdata;
    logic gotMis, pBusy, pDone;
    ops  = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    adrs = '{32'h16, 32'h17, 32'h16, 32'h14};
    exps = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    mem[5]    = 32'h80FF7F01;
    refMem[5] = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      runAccess(ops[i], adrs[i], 32'h0, 1'b0, lat, nr, nw, stable, gotRdata, gotMis, pBusy, pDone);
      nVectors += 3;
      if (lat !== 3) begin nMiscompares++; $display("[TB] FAIL load%0d_latency: got %0d expected 3", i, lat); end
      if (gotRdata !== exps[i]) begin nMiscompares++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, gotRdata, exps[i]); end
      if (nr !== 1 || nw !== 0) begin nMiscompares++; $display("[TB] FAIL load%0d_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", i, nr, nw); end
      expRdata = exps[i];
    end
  endtask

  // Unaligned word load: flagged when the check is built in, else the
  // low address bits are ignored and the containing word is returned.
  task automatic test_misalign();
    int lat, nr, nw;
    bit stable;
    logic [31:0] gotRdata, expWord;
    logic gotMis, pBusy, pDone;
    expWord = ALIGN_EN ? expRdata : refMem[3];
    runAccess(OP_LW, 32'h0E, 32'h0, 1'b0, lat, nr, nw, stable, gotRdata, gotMis, pBusy, pDone);
    nVectors += 4;
    if (lat !== (ALIGN_EN ? 1 : 3)) begin nMiscompares++; $display("[TB] FAIL misalign_latency: got %0d expected %0d", lat, ALIGN_EN ? 1 : 3); end
    if (gotMis !== ALIGN_EN) begin nMiscompares++; $display("[TB] FAIL misalign_flag: got %b expected %b", gotMis, ALIGN_EN); end
    if (nr !== (ALIGN_EN ? 0 : 1) || nw !== 0) begin nMiscompares++; $display("[TB] FAIL misalign_strobes: got rd=%0d wr=%0d", nr, nw); end
    if (gotRdata !== expWord) begin nMiscompares++; $display("[TB] FAIL misalign_rdata: got %h expected %h", gotRdata, expWord); end
    expRdata = expWord;
  endtask

  // sb into the middle of a word: read-modify-write, five cycles.
  task automatic test_sub_word_store();
    int lat, nr, nw;
    bit stable;
    logic [31:0] gotRdata;
    logic gotMis, pBusy, pDone;
    mem[2]    = 32'h11223344;
    refMem[2] = 32'h1122AB44;
    runAccess(OP_SB, 32'h09, 32'h000000AB, 1'b0, lat, nr, nw, stable, gotRdata, gotMis, pBusy, pDone);
    nVectors += 5;
    if (nr !== 1) begin nMiscompares++; $display("[TB] FAIL sb_reads: got %0d expected 1", nr); end
    if (nw !== 1) begin nMiscompares++; $display("[TB] FAIL sb_writes: got %0d expected 1", nw); end
    if (lat !== 5) begin nMiscompares++; $display("[TB] FAIL sb_latency: got %0d expected 5", lat); end
    if (mem[2] !== 32'h1122AB44) begin nMiscompares++; $display("[TB] FAIL sb_memory: got %h expected 1122ab44", mem[2]); end
    if (gotRdata !== expRdata) begin nMiscompares++; $display("[TB] FAIL sb_rdata_hold: got %h expected %h", gotRdata, expRdata); end
  endtask

  // sw with req held high and inputs churning while busy.
  task automatic test_word_store();
    int lat, nr, nw;
    bit stable;
    logic [31:0] gotRdata;
    logic gotMis, pBusy, pDone;
    runAccess(OP_SW, 32'h0C, 32'hDEADBEEF, 1'b1, lat, nr, nw, stable, gotRdata, gotMis, pBusy, pDone);
    refMem[3] = 32'hDEADBEEF;
    nVectors += 6;
    if (nr !== 0) begin nMiscompares++; $display("[TB] FAIL sw_reads: got %0d expected 0", nr); end
    if (nw !== 1) begin nMiscompares++; $display("[TB] FAIL sw_writes: got %0d expected 1", nw); end
    if (lat !== 3) begin nMiscompares++; $display("[TB] FAIL sw_latency: got %0d expected 3", lat); end
    if (mem[3] !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL sw_memory: got %h expected deadbeef", mem[3]); end
    if (!stable) begin nMiscompares++; $display("[TB] FAIL sw_address_stable: got unstable expected stable"); end
    if (pBusy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL sw_ignored_req: got busy=%b expected 0", pBusy); end
  endtask

  // sh aborted by reset while in CAPT: no write, no done, memory untouched.
  task automatic test_reset_abort();
    int nw, nd;
    mem[2]    = 32'h55667788;
    refMem[2] = 32'h55667788;
    req   = 1'b1;
    op    = OP_SH;
    addr  = 32'h0A;
    wdata = 32'h0000CAFE;
    step();
    req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    nVectors += 5;
    if (mem_memWrite !== 1'b0 || mem_memRead !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_strobes: got rd=%b wr=%b expected 0", mem_memRead, mem_memWrite); end
    if (done !== 1'b0 || busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_done_busy: got done=%b busy=%b expected 0", done, busy); end
    if (rdata !== 32'h0 || misalign !== 1'b0) begin nMiscompares++; $display("[TB] FAIL abort_rdata: got %h mis=%b expected 0", rdata, misalign); end
    if (mem_address !== 32'h0 || mem_writeData !== 32'h0) begin nMiscompares++; $display("[TB] FAIL abort_mem_outputs: got %h %h expected 0", mem_address, mem_writeData); end
    nw = 0;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (mem_memWrite === 1'b1) nw++;
      if (done === 1'b1) nd++;
    end
    if (nw !== 0 || nd !== 0) begin nMiscompares++; $display("[TB] FAIL abort_after: got writes=%0d dones=%0d expected 0", nw, nd); end
    nVectors++;
    if (mem[2] !== 32'h55667788) begin nMiscompares++; $display("[TB] FAIL abort_memory: got %h expected 55667788", mem[2]); end
    expRdata = 32'h0;
  endtask

  // Random ops/addresses/data checked against the reference memory.
  task automatic test_random();
    int lat, nr, nw, idx, nb, expLat, expRd, expWr;
    bit stable, mis, scr;
    logic [3:0]  o;
    logic [31:0] a, d, gotRdata;
    logic gotMis, pBusy, pDone;
    for (int i = 0; i < 200; i++) begin
      o   = 4'($urandom);
      a   = $urandom;
      d   = $urandom;
      scr = 1'($urandom_range(0, 1));
      idx = int'((a >> 2) % 64);
      nb  = accessBytes(o);
      mis = modelMisaligned(o, a);
      expLat = mis ? 1 : ((!o[3] || nb == 4) ? 3 : 5);
      expRd  = (mis || (o[3] && nb == 4)) ? 0 : 1;
      expWr  = (o[3] && !mis) ? 1 : 0;
      if (!o[3] && !mis) expRdata = modelLoad(refMem[idx], o, a);
      if (o[3] && !mis) refMem[idx] = modelStore(refMem[idx], o, a, d);
      runAccess(o, a, d, scr, lat, nr, nw, stable, gotRdata, gotMis, pBusy, pDone);
      nVectors += 8;
      if (lat !== expLat) begin nMiscompares++; $display("[TB] FAIL rnd%0d_latency: op=%h addr=%h got %0d expected %0d", i, o, a, lat, expLat); end
      if (nr !== expRd) begin nMiscompares++; $display("[TB] FAIL rnd%0d_reads: got %0d expected %0d", i, nr, expRd); end
      if (nw !== expWr) begin nMiscompares++; $display("[TB] FAIL rnd%0d_writes: got %0d expected %0d", i, nw, expWr); end
      if (!stable) begin nMiscompares++; $display("[TB] FAIL rnd%0d_address: got unstable expected %h", i, a >> 2); end
      if (gotRdata !== expRdata) begin nMiscompares++; $display("[TB] FAIL rnd%0d_rdata: op=%h addr=%h got %h expected %h", i, o, a, gotRdata, expRdata); end
      if (gotMis !== mis) begin nMiscompares++; $display("[TB] FAIL rnd%0d_misalign: got %b expected %b", i, gotMis, mis); end
      if (pBusy !== 1'b0 || pDone !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rnd%0d_return_idle: got busy=%b done=%b expected 0", i, pBusy, pDone); end
      if (mem[idx] !== refMem[idx]) begin nMiscompares++; $display("[TB] FAIL rnd%0d_memory: op=%h addr=%h got %h expected %h", i, o, a, mem[idx], refMem[idx]); end
    end
    for (int w = 0; w < 64; w++) begin
      nVectors++;
      if (mem[w] !== refMem[w]) begin nMiscompares++; $display("[TB] FAIL final_memory[%0d]: got %h expected %h", w, mem[w], refMem[w]); end
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    reset        = 1'b1;
    req          = 1'b0;
    op           = 4'h0;
    addr         = 32'h0;
    wdata        = 32'h0;
    mem_readData = 32'h0;
    expRdata     = 32'h0;
    for (int w = 0; w < 64; w++) begin
      mem[w]    = $urandom;
      refMem[w] = mem[w];
    end
    test_reset();
    test_loads();
    test_misalign();
    test_sub_word_store();
    test_word_store();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
